// File: rtl/fuel_pkg.sv
// Shared types and helpers for the fuel supply arbiter family.
// Holds FSM state encodings, station-count limits and a clog2 helper.
package fuel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_e;

    localparam int MIN_PUMPS = 2;
    localparam int MAX_PUMPS = 8;

    // Ceiling log2, never below 1 so 1-bit fields stay legal.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fuel_supply_arbiter_if.sv
// Station/supply bundle for the fuel supply arbiter.
// master: station side drives req/flow_pulse; slave: arbiter drives the rest.
interface fuel_supply_arbiter_if
    import fuel_pkg::*;
#(
    parameter int N_PUMPS = 4,
    parameter int CNT_W   = 16
) ();

    localparam int OW = clog2(N_PUMPS);

    logic [N_PUMPS-1:0] req;
    logic               flow_pulse;
    logic [N_PUMPS-1:0] grant;
    logic [OW-1:0]      owner;
    logic               fuel_out;
    logic               busy;
    logic [CNT_W-1:0]   vol_count;
    logic               vol_valid;
    logic [1:0]         State_out;

    modport master (
        output req, flow_pulse,
        input  grant, owner, fuel_out, busy,
        input  vol_count, vol_valid, State_out
    );

    modport slave (
        input  req, flow_pulse,
        output grant, owner, fuel_out, busy,
        output vol_count, vol_valid, State_out
    );

endinterface

// File: rtl/pump_rr_arbiter.sv
// Combinational rotating-priority picker.
// Ports: req, ptr (last winner) in; win_oh, win_idx, any_req out.
module pump_rr_arbiter
    import fuel_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          any_req
);

    int   idx;
    logic found;

    // Search upward from ptr+1 with wrap, so the last winner is last.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fuel_supply_arbiter.sv
// Shares one fuel supply among N_PUMPS stations: round-robin grant,
// slice preemption, dead-time gap and per-session volume count.
// Ports: clk, reset (sync, active-high), bus (slave side of the bundle).
module fuel_supply_arbiter
    import fuel_pkg::*;
#(
    parameter int N_PUMPS       = 4,
    parameter int MAX_GRANT_CYC = 1000,
    parameter int GAP_CYC       = 4,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fuel_supply_arbiter_if.slave bus
);

    localparam int OW = clog2(N_PUMPS);
    localparam int TW = clog2(MAX_GRANT_CYC + 1);
    localparam int GW = clog2(GAP_CYC + 1);

    localparam logic [TW-1:0] T_MAX   = TW'(MAX_GRANT_CYC);
    localparam logic [GW-1:0] G_LAST  = GW'(GAP_CYC - 1);
    localparam logic [OW-1:0] PTR_RST = OW'(N_PUMPS - 1);

    if (N_PUMPS < MIN_PUMPS || N_PUMPS > MAX_PUMPS) begin : g_bad_n
        $error("N_PUMPS out of range");
    end

    state_e             state_q, state_d;
    logic [N_PUMPS-1:0] grant_q, grant_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic               fuel_q, fuel_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   vol_q, vol_d;
    logic               vv_q, vv_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [GW-1:0]      gap_q, gap_d;

    logic [N_PUMPS-1:0] win_oh;
    logic [OW-1:0]      win_idx;
    logic               any_req;
    logic               own_req;
    logic               others;

    pump_rr_arbiter #(
        .N  (N_PUMPS),
        .IW (OW)
    ) u_rr (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        fuel_d  = fuel_q;
        vol_d   = vol_q;
        vv_d    = 1'b0;
        timer_d = timer_q;
        gap_d   = gap_q;
        own_req = bus.req[owner_q];
        others  = |(bus.req & ~grant_q);

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                fuel_d  = 1'b0;
                if (any_req) begin
                    state_d = RUN;
                    grant_d = win_oh;
                    owner_d = win_idx;
                    ptr_d   = win_idx;
                    fuel_d  = 1'b1;
                    vol_d   = '0;
                    timer_d = '0;
                end
            end
            RUN: begin
                if (bus.flow_pulse && !(&vol_q))
                    vol_d = vol_q + 1'b1;
                if (timer_q < T_MAX)
                    timer_d = timer_q + 1'b1;
                // Slice only ends early when someone else is waiting.
                if (!own_req || (timer_q >= T_MAX && others)) begin
                    state_d = DRAIN;
                    grant_d = '0;
                    fuel_d  = 1'b0;
                    vv_d    = 1'b1;
                    gap_d   = '0;
                end
            end
            DRAIN: begin
                grant_d = '0;
                fuel_d  = 1'b0;
                gap_d   = gap_q + 1'b1;
                if (gap_q >= G_LAST)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
                ptr_d   = PTR_RST;
                fuel_d  = 1'b0;
                vol_d   = '0;
                timer_d = '0;
                gap_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= PTR_RST;
            fuel_q  <= 1'b0;
            busy_q  <= 1'b0;
            vol_q   <= '0;
            vv_q    <= 1'b0;
            timer_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            fuel_q  <= fuel_d;
            busy_q  <= busy_d;
            vol_q   <= vol_d;
            vv_q    <= vv_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.owner     = owner_q;
    assign bus.fuel_out  = fuel_q;
    assign bus.busy      = busy_q;
    assign bus.vol_count = vol_q;
    assign bus.vol_valid = vv_q;
    assign bus.State_out = state_q;

endmodule

// File: doc/fuel_supply_arbiter.md
Name: fuel_supply_arbiter

Overview:
- Shares one fuel supply motor/valve among N_PUMPS nozzle stations; each station's gas pump controller raises a request when its nozzle is lifted and pressure is good.
- Round-robin grant, one owner at a time, with a time-slice preemption limit and a dead-time gap between owners.
- Counts flow-meter pulses per session and reports the dispensed volume at session end.

Parameters:
- N_PUMPS, 4, number of requesting stations (2..8).
- MAX_GRANT_CYC, 1000, RUN cycles after which the owner is preempted if another request is pending.
- GAP_CYC, 4, dead-time cycles (supply off, no grant) between sessions; at least 1.
- CNT_W, 16, width of the volume counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N_PUMPS  per-station request; level, held for the whole session.
- flow_pulse  in  1  one-cycle pulse per unit volume from the shared flow meter.
- grant  out  N_PUMPS  one-hot grant to the current owner; 0 when no owner.
- owner  out  clog2(N_PUMPS)  index of the current or last owner.
- fuel_out  out  1  supply motor/valve enable.
- busy  out  1  state is not IDLE.
- vol_count  out  CNT_W  volume of the current session; holds the last session value until the next grant.
- vol_valid  out  1  one-cycle pulse; vol_count is final.
- State_out  out  2  present-state encoding.

Behaviour:
- All outputs are registered. Reset acts on the clk edge and has priority over everything else.
- Reset values: State_out=IDLE, grant=0, owner=0, fuel_out=0, busy=0, vol_count=0, vol_valid=0, rr pointer=N_PUMPS-1, so station 0 wins first.
- State encoding: IDLE=2'b00, RUN=2'b01, DRAIN=2'b10. 2'b11 is illegal and recovers to IDLE with all outputs 0.
- IDLE:
  - If req is nonzero, pick the first set bit searching upward from pointer+1 with wrap-around.
  - Next edge: go to RUN; grant is one-hot, owner and pointer take the winner, vol_count is cleared, and the slice timer is cleared.
  - Latency: req sampled at edge k produces grant and fuel_out at edge k+1.
- RUN:
  - fuel_out=1.
  - Each flow_pulse increments vol_count, saturating at all ones.
  - The slice timer increments and saturates at MAX_GRANT_CYC.
  - Exit to DRAIN when req[owner]=0, or when timer>=MAX_GRANT_CYC and any other req bit is set (preemption).
  - With no competitor, RUN continues indefinitely past the limit.
  - fuel_out drops on the same edge as grant, one cycle after req[owner] falls.
- DRAIN:
  - grant=0 and fuel_out=0; flow_pulse is ignored.
  - vol_valid=1 in the first DRAIN cycle only.
  - After GAP_CYC cycles go to IDLE, which re-arbitrates in that cycle.
  - Minimum idle gap on the supply between owners: GAP_CYC+1 cycles.
  - A preempted station that keeps req high re-enters arbitration normally and now has lowest priority.
- flow_pulse in IDLE is ignored.
- Simultaneous requests are resolved by the round-robin order only.
- A request that arrives in the same cycle the owner's req drops still waits for DRAIN.
- Reset mid-session: no vol_valid; vol_count is cleared.

Decomposition:
- Shared package fuel_pkg holds:
  - state encodings IDLE, RUN, DRAIN;
  - station-count limits;
  - the clog2 helper function.
- One sub-module, pump_rr_arbiter: combinational rotating-priority picker; inputs req and pointer; outputs one-hot winner, index and any_req. Also reused by future nozzle/payment blocks.
- The FSM, slice timer, gap counter and volume counter stay in the top-level block.

Test Plan (N_PUMPS=4, MAX_GRANT_CYC=8, GAP_CYC=2, CNT_W=4 unless noted):
- Reset held 3 cycles with req=4'b1111 -> grant=0, fuel_out=0, busy=0, State_out=00, vol_count=0 throughout.
- Single session:
  - req=4'b0001 at edge 1 -> grant=0001, fuel_out=1, State_out=01 at edge 2.
  - 5 flow_pulses, then req=0 -> next edge: State_out=10, fuel_out=0, vol_valid=1, vol_count=5.
  - Edge+2: State_out=00, busy=0.
- Simultaneous requests:
  - req=4'b1010 out of reset -> grant=0010 first.
  - Drop req[1] -> after DRAIN, grant=1000; fuel_out is low for exactly 3 cycles between sessions.
- Preemption:
  - req[0] held, req[2] raised after the grant -> after 8 RUN cycles go to DRAIN, then grant=0100.
  - Repeat with req[2]=0 -> grant=0001 stays asserted beyond 20 cycles.
- Saturation: 20 flow_pulses in one session -> vol_count=15 and vol_valid reports 15. Pulses during IDLE/DRAIN leave vol_count unchanged.
- Reset during RUN with vol_count=3 -> next edge: grant=0, fuel_out=0, vol_count=0, vol_valid never pulses. The pointer resets, so station 0 wins the next contention.
